// File: rtl/acos_rr_scheduler.sv
// acos_rr_scheduler: round-robin arbiter that shares one acos engine among
// N_REQ requesters. One transaction is in flight at a time:
// IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Optional feature macro: ACOS_SCHED_WDOG_EN. When it is defined, a watchdog
// aborts a WAIT that lasts TIMEOUT cycles and returns rsp_err=1 with theta=0.
module acos_rr_scheduler #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_x,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_theta,
    output logic                  rsp_err,
    output logic                  eng_start,
    output logic [31:0]           eng_x,
    input  logic [31:0]           eng_theta,
    input  logic                  eng_valid,
    input  logic                  eng_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    logic [N_REQ-1:0]  req_ready_r;
    logic              rsp_valid_r;
    logic [ID_W-1:0]   rsp_id_r;
    logic [31:0]       rsp_theta_r;
    logic              rsp_err_r;
    logic              eng_start_r;
    logic [31:0]       eng_x_r;
    logic [ID_W-1:0]   id_r;
    logic [ID_W-1:0]   rr_ptr_r;

    logic [ID_W-1:0]   cand_s;
    logic [ID_W-1:0]   grant_idx_s;
    logic              grant_found_s;
    logic              do_grant_s;
    logic              do_capture_s;
    logic              do_abort_s;
    logic              do_release_s;
    logic              wdog_expired_s;

`ifdef ACOS_SCHED_WDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  wdog_cnt_r;

    // Watchdog fires on the TIMEOUT-th consecutive WAIT cycle without a result.
    always_comb begin
        wdog_expired_s = 1'b0;
        if (wdog_cnt_r >= CNT_W'(TIMEOUT - 1)) begin
            wdog_expired_s = 1'b1;
        end else begin
            wdog_expired_s = 1'b0;
        end
    end

    // Watchdog counter: cleared while entering WAIT, counts every WAIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt_r <= '0;
        end else if (state_r == ISSUE) begin
            wdog_cnt_r <= '0;
        end else if (state_r == WAIT) begin
            wdog_cnt_r <= wdog_cnt_r + CNT_W'(1);
        end
    end
`else
    // Without the watchdog WAIT only ends on an engine result.
    always_comb begin
        wdog_expired_s = 1'b0;
    end
`endif

    // Rotating priority search: the lowest offset after rr_ptr wins, so the
    // loop runs from the farthest candidate down and the nearest one overwrites.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand_s = ID_W'((int'(rr_ptr_r) + k) % N_REQ);
            if (req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Next-state logic and single-cycle action strobes for the datapath.
    always_comb begin
        state_nxt_s  = state_r;
        do_grant_s   = 1'b0;
        do_capture_s = 1'b0;
        do_abort_s   = 1'b0;
        do_release_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_found_s && !eng_busy) begin
                    do_grant_s  = 1'b1;
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                state_nxt_s = WAIT;
            end
            WAIT: begin
                if (eng_valid) begin
                    do_capture_s = 1'b1;
                    state_nxt_s  = RESP;
                end else if (wdog_expired_s) begin
                    do_abort_s  = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    do_release_s = 1'b1;
                    state_nxt_s  = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: grant/issue registers, round-robin pointer and response hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_r <= '0;
            eng_start_r <= 1'b0;
            eng_x_r     <= 32'h0000_0000;
            id_r        <= '0;
            rr_ptr_r    <= ID_W'(N_REQ - 1);
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_theta_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            // Both pulses are high exactly during the ISSUE cycle.
            req_ready_r <= do_grant_s ? (N_REQ'(1'b1) << grant_idx_s) : '0;
            eng_start_r <= do_grant_s;
            if (do_grant_s) begin
                id_r    <= grant_idx_s;
                eng_x_r <= req_x[{grant_idx_s, 5'b00000} +: 32];
            end
            if (state_r == ISSUE) begin
                rr_ptr_r <= id_r;
            end
            if (do_capture_s) begin
                rsp_valid_r <= 1'b1;
                rsp_id_r    <= id_r;
                rsp_theta_r <= eng_theta;
                rsp_err_r   <= 1'b0;
            end else if (do_abort_s) begin
                rsp_valid_r <= 1'b1;
                rsp_id_r    <= id_r;
                rsp_theta_r <= 32'h0000_0000;
                rsp_err_r   <= 1'b1;
            end else if (do_release_s) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_theta = rsp_theta_r;
    assign rsp_err   = rsp_err_r;
    assign eng_start = eng_start_r;
    assign eng_x     = eng_x_r;

endmodule

// File: tb/tb_acos_rr_scheduler.sv
// Bench for acos_rr_scheduler: behavioural acos engine stub plus a scoreboard
// of expected {id, theta, err} popped on every response handshake.
module tb_acos_rr_scheduler;

    localparam int N  = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [32*N-1:0] req_x = '0;
    logic [N-1:0]  req_ready;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_id;
    logic [31:0]   rsp_theta;
    logic          rsp_err;
    logic          eng_start;
    logic [31:0]   eng_x;
    logic [31:0]   eng_theta = 32'h0;
    logic          eng_valid = 1'b0;
    logic          eng_busy  = 1'b0;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] theta;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [N-1:0] ready_q[$];
    logic [31:0] start_x_q[$];
    logic [31:0] last_theta;
    int          checks = 0;
    int          errors = 0;
    int          start_cnt = 0;
    int          grant_cnt = 0;
    int          hold_n = 0;
    bit          stub_mute = 1'b0;
    int          stub_cnt = 0;

    acos_rr_scheduler #(.N_REQ(N), .ID_W(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_theta(rsp_theta), .rsp_err(rsp_err),
        .eng_start(eng_start), .eng_x(eng_x), .eng_theta(eng_theta),
        .eng_valid(eng_valid), .eng_busy(eng_busy)
    );

    always #5 clk = ~clk;

    // Reference acos in Q16.16; the engine saturates |x| >= 0.96875 to +-1.
    function automatic logic [31:0] acos_ref(input logic [31:0] x);
        real r;
        r = $itor($signed(x)) / 65536.0;
        if (r >= 0.96875) r = 1.0;
        if (r <= -0.96875) r = -1.0;
        return 32'($rtoi($acos(r) * 65536.0 + 0.5));
    endfunction

    // Engine stub: result pulse 5 cycles after the ISSUE cycle, busy meanwhile.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_valid <= 1'b0;
            eng_busy  <= 1'b0;
            stub_cnt  <= 0;
        end else begin
            eng_valid <= 1'b0;
            if (eng_start && !stub_mute) begin
                eng_busy  <= 1'b1;
                stub_cnt  <= 4;
                eng_theta <= acos_ref(eng_x);
            end else if (stub_cnt == 1) begin
                eng_valid <= 1'b1;
                eng_busy  <= 1'b0;
                stub_cnt  <= 0;
            end else if (stub_cnt > 1) begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    // Scoreboard monitor: one pop per response handshake.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            checks++;
            last_theta = rsp_theta;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_rsp got id=%0d theta=%h err=%b, none expected",
                         rsp_id, rsp_theta, rsp_err);
            end else begin
                mon_e = sb_q.pop_front();
                if ({rsp_id, rsp_theta, rsp_err} !== mon_e) begin
                    errors++;
                    $display("FAIL sb_rsp got id=%0d theta=%h err=%b exp id=%0d theta=%h err=%b",
                             rsp_id, rsp_theta, rsp_err, mon_e.id, mon_e.theta, mon_e.err);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle: record starts/grants, retire granted requests.
    task automatic step();
        tick();
        if (eng_start) begin
            start_cnt++;
            start_x_q.push_back(eng_x);
        end
        if (req_ready != '0) begin
            ready_q.push_back(req_ready);
            grant_cnt++;
            if (hold_n > 0) begin
                if (grant_cnt >= hold_n) req_valid = '0;
            end else begin
                req_valid = req_valid & ~req_ready;
            end
        end
    endtask

    task automatic clear_rec();
        start_cnt = 0;
        grant_cnt = 0;
        ready_q.delete();
        start_x_q.delete();
    endtask

    // Run until every request is retired and every response consumed.
    task automatic run(input int max_cyc, input string name);
        int n;
        n = 0;
        while (1) begin
            step();
            if (req_valid == '0 && sb_q.size() == 0 && !rsp_valid) break;
            n++;
            if (n >= max_cyc) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout got pending=%0d exp 0", name, sb_q.size());
                sb_q.delete();
                req_valid = '0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks += 7;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
        if (rsp_theta !== 32'h0) begin errors++; $display("FAIL reset_rsp_theta got %h exp 0", rsp_theta); end
        if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
        if (eng_start !== 1'b0) begin errors++; $display("FAIL reset_eng_start got %b exp 0", eng_start); end
        if (eng_x !== 32'h0) begin errors++; $display("FAIL reset_eng_x got %h exp 0", eng_x); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int d;
        clear_rec();
        hold_n = 0;
        rsp_ready = 1'b1;
        req_x[31:0] = 32'h0000_0000;
        sb_q.push_back('{id: 2'd0, theta: acos_ref(32'h0), err: 1'b0});
        req_valid = 4'b0001;
        run(100, "single");
        checks += 3;
        if (start_cnt != 1) begin errors++; $display("FAIL single_start_cycles got %0d exp 1", start_cnt); end
        if (ready_q.size() != 1 || ready_q[0] !== 4'b0001) begin
            errors++; $display("FAIL single_req_ready got %0d pulses exp 1 pulse on bit 0", ready_q.size());
        end
        d = int'(last_theta) - 32'h0001_921F;
        if (d > 2 || d < -2) begin errors++; $display("FAIL single_theta got %h exp 0001921f +-2", last_theta); end
    endtask

    task automatic test_round_robin();
        logic [31:0] xs[4];
        logic [N-1:0] exp_r;
        xs[0] = 32'h0000_8000; xs[1] = 32'hFFFF_8000;
        xs[2] = 32'h0000_4000; xs[3] = 32'h0000_C000;
        do_reset();
        clear_rec();
        for (int i = 0; i < 4; i++) req_x[32*i +: 32] = xs[i];
        for (int g = 0; g < 5; g++) sb_q.push_back('{id: 2'(g % 4), theta: acos_ref(xs[g % 4]), err: 1'b0});
        rsp_ready = 1'b1;
        hold_n = 5;
        req_valid = 4'b1111;
        run(300, "round_robin");
        hold_n = 0;
        for (int g = 0; g < 5; g++) begin
            exp_r = 4'b0001 << (g % 4);
            checks++;
            if (g >= ready_q.size() || ready_q[g] !== exp_r) begin
                errors++; $display("FAIL rr_grant%0d got %b exp %b", g,
                                   (g < ready_q.size()) ? ready_q[g] : 4'bxxxx, exp_r);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] h_id;
        logic [31:0] h_th;
        int n;
        clear_rec();
        rsp_ready = 1'b0;
        req_x[63:32] = 32'h0000_2000;
        req_x[95:64] = 32'hFFFF_C000;
        sb_q.push_back('{id: 2'd1, theta: acos_ref(32'h0000_2000), err: 1'b0});
        sb_q.push_back('{id: 2'd2, theta: acos_ref(32'hFFFF_C000), err: 1'b0});
        req_valid = 4'b0110;
        n = 0;
        while (!rsp_valid && n < 50) begin step(); n++; end
        checks++;
        if (!rsp_valid) begin errors++; $display("FAIL bp_rsp_valid got 0 exp 1 within 50 cycles"); end
        h_id = rsp_id;
        h_th = rsp_theta;
        start_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks += 3;
            if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc%0d got %b exp 1", i, rsp_valid); end
            if (rsp_id !== h_id || rsp_theta !== h_th) begin
                errors++; $display("FAIL bp_hold_data cyc%0d got %0d/%h exp %0d/%h", i, rsp_id, rsp_theta, h_id, h_th);
            end
            if (eng_start !== 1'b0) begin errors++; $display("FAIL bp_no_start cyc%0d got %b exp 0", i, eng_start); end
        end
        rsp_ready = 1'b1;
        run(200, "backpressure");
        checks++;
        if (ready_q.size() != 2 || ready_q[1] !== 4'b0100) begin
            errors++; $display("FAIL bp_second_grant got %0d grants exp 2 ending on bit 2", ready_q.size());
        end
    endtask

    task automatic test_clamp();
        clear_rec();
        rsp_ready = 1'b1;
        req_x[95:64]  = 32'h0000_F800;
        req_x[127:96] = 32'hFFFF_0000;
        sb_q.push_back('{id: 2'd3, theta: 32'h0003_243F, err: 1'b0});
        sb_q.push_back('{id: 2'd2, theta: 32'h0000_0000, err: 1'b0});
        req_valid = 4'b1100;
        run(200, "clamp");
        checks += 2;
        if (start_x_q.size() < 1 || start_x_q[0] !== 32'hFFFF_0000) begin
            errors++; $display("FAIL clamp_eng_x_req3 got %h exp ffff0000", (start_x_q.size() > 0) ? start_x_q[0] : 32'hx);
        end
        if (start_x_q.size() < 2 || start_x_q[1] !== 32'h0000_F800) begin
            errors++; $display("FAIL clamp_eng_x_req2 got %h exp 0000f800", (start_x_q.size() > 1) ? start_x_q[1] : 32'hx);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_rec();
        rsp_ready = 1'b1;
        req_x[63:32] = 32'h0000_1000;
        req_valid = 4'b0010;
        n = 0;
        while (start_cnt == 0 && n < 30) begin step(); n++; end
        step();
        step();
        rst = 1'b1;
        req_valid = '0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_theta, rsp_err, eng_start, eng_x} !== '0) begin
            errors++; $display("FAIL midrst_outputs got rdy=%b v=%b id=%0d th=%h e=%b st=%b x=%h exp all 0",
                               req_ready, rsp_valid, rsp_id, rsp_theta, rsp_err, eng_start, eng_x);
        end
        tick();
        rst = 1'b0;
        clear_rec();
        req_x[31:0]  = 32'h0000_3000;
        req_x[95:64] = 32'hFFFF_D000;
        sb_q.push_back('{id: 2'd0, theta: acos_ref(32'h0000_3000), err: 1'b0});
        sb_q.push_back('{id: 2'd2, theta: acos_ref(32'hFFFF_D000), err: 1'b0});
        req_valid = 4'b0101;
        run(200, "reset_mid");
        checks++;
        if (ready_q.size() < 1 || ready_q[0] !== 4'b0001) begin
            errors++; $display("FAIL midrst_first_grant got %b exp 0001", (ready_q.size() > 0) ? ready_q[0] : 4'bxxxx);
        end
    endtask

`ifdef ACOS_SCHED_WDOG_EN
    task automatic test_wdog();
        clear_rec();
        rsp_ready = 1'b1;
        stub_mute = 1'b1;
        req_x[63:32] = 32'h0000_4000;
        sb_q.push_back('{id: 2'd1, theta: 32'h0, err: 1'b1});
        req_valid = 4'b0010;
        run(100, "wdog_abort");
        stub_mute = 1'b0;
        req_x[95:64] = 32'h0000_6000;
        sb_q.push_back('{id: 2'd2, theta: acos_ref(32'h0000_6000), err: 1'b0});
        req_valid = 4'b0100;
        run(100, "wdog_recover");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_clamp();
        test_reset_mid();
`ifdef ACOS_SCHED_WDOG_EN
        test_wdog();
`endif
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
